// File: rtl/upower_decode_stage_pkg.sv
// ============================================================================
// upower_pkg : formats, opcode constants, decoded bundle, classifier helper
// Rev 1.0
// ============================================================================
`default_nettype none

package upower_pkg;

    typedef enum logic [2:0] {
        FMT_ILL = 3'd0,
        FMT_XO  = 3'd1,
        FMT_X   = 3'd2,
        FMT_B   = 3'd3,
        FMT_I   = 3'd4,
        FMT_D   = 3'd5,
        FMT_DS  = 3'd6
    } fmt_e;

    localparam logic [5:0] C_OP_XFAM = 6'd31;
    localparam logic [5:0] C_OP_B    = 6'd19;
    localparam logic [5:0] C_OP_I    = 6'd18;
    localparam logic [5:0] C_OP_DS0  = 6'd58;
    localparam logic [5:0] C_OP_DS1  = 6'd62;

    localparam logic [9:0] C_XOX_AND  = 10'd28;
    localparam logic [9:0] C_XOX_NAND = 10'd476;
    localparam logic [9:0] C_XOX_OR   = 10'd444;
    localparam logic [9:0] C_XOX_XOR  = 10'd316;
    localparam logic [9:0] C_XOX_EXTS = 10'd986;

    localparam logic [8:0] C_XOXO_ADD  = 9'd266;
    localparam logic [8:0] C_XOXO_SUBF = 9'd40;

    typedef struct packed {
        fmt_e        fmt;
        logic        illegal;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  bo;
        logic [4:0]  bi;
        logic [15:0] si;
        logic [13:0] ds;
        logic [9:0]  xox;
        logic [8:0]  xoxo;
        logic        aa;
        logic [1:0]  xods;
    } bundle_t;

    function automatic fmt_e classify(input logic [31:0] instr);
        logic [5:0] op;
        logic [9:0] xox;
        logic [8:0] xoxo;
        op   = instr[31:26];
        xox  = instr[10:1];
        xoxo = instr[9:1];
        if (op == C_OP_XFAM && (xox == C_XOX_AND || xox == C_XOX_NAND ||
                                xox == C_XOX_OR  || xox == C_XOX_XOR  ||
                                xox == C_XOX_EXTS))
            return FMT_X;
        if (op == C_OP_XFAM && (xoxo == C_XOXO_ADD || xoxo == C_XOXO_SUBF))
            return FMT_XO;
        if (op == C_OP_B)
            return FMT_B;
        if (op == C_OP_I)
            return FMT_I;
        case (op)
            6'd14, 6'd15, 6'd24, 6'd26, 6'd28, 6'd32, 6'd34,
            6'd36, 6'd37, 6'd38, 6'd40, 6'd42, 6'd44: return FMT_D;
            default: ;
        endcase
        if (op == C_OP_DS0 || op == C_OP_DS1)
            return FMT_DS;
        return FMT_ILL;
    endfunction

endpackage

`default_nettype wire

// File: rtl/upower_decode_stage_if.sv
// ============================================================================
// upower_decode_stage_if : input handshake and decoded-bundle output bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface upower_decode_stage_if
    import upower_pkg::*;
#(
    parameter int PC_W = 64
) ();
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    fmt_e            out_fmt;
    logic            out_illegal;
    logic [PC_W-1:0] out_pc;
    logic [5:0]      out_opcode;
    logic [4:0]      out_rs;
    logic [4:0]      out_rt;
    logic [4:0]      out_bo;
    logic [4:0]      out_bi;
    logic [15:0]     out_si;
    logic [13:0]     out_ds;
    logic [9:0]      out_xox;
    logic [8:0]      out_xoxo;
    logic            out_aa;
    logic [1:0]      out_xods;

    // master: the decode stage itself
    modport master (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_fmt, out_illegal, out_pc, out_opcode,
               out_rs, out_rt, out_bo, out_bi, out_si, out_ds, out_xox,
               out_xoxo, out_aa, out_xods
    );

    modport slave (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_fmt, out_illegal, out_pc, out_opcode,
               out_rs, out_rt, out_bo, out_bi, out_si, out_ds, out_xox,
               out_xoxo, out_aa, out_xods
    );
endinterface

`default_nettype wire

// File: rtl/upower_decode_stage_field_decode.sv
// ============================================================================
// upower_field_decode : combinational classifier and field gater
// Rev 1.0
// ============================================================================
`default_nettype none

module upower_field_decode
    import upower_pkg::*;
(
    input  wire logic [31:0] instr,
    output bundle_t          bundle
);

    fmt_e fmt;

    always_comb begin
        fmt            = classify(instr);
        bundle         = '0;
        bundle.fmt     = fmt;
        bundle.opcode  = instr[31:26];
        // Fields foreign to a format are forced to zero so the ALU can key off them
        case (fmt)
            FMT_X, FMT_XO, FMT_B, FMT_D, FMT_DS: begin
                bundle.rt   = instr[25:21];
                bundle.bo   = instr[25:21];
                bundle.rs   = instr[20:16];
                bundle.bi   = instr[20:16];
                bundle.aa   = instr[1];
                bundle.xods = instr[1:0];
            end
            default: ;
        endcase
        case (fmt)
            FMT_X:   bundle.xox  = instr[10:1];
            FMT_XO:  bundle.xoxo = instr[9:1];
            FMT_D:   bundle.si   = instr[15:0];
            FMT_DS:  bundle.ds   = instr[15:2];
            FMT_ILL: bundle.illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/upower_decode_stage.sv
// ============================================================================
// upower_decode_stage : registered decode stage with 2-entry skid buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module upower_decode_stage
    import upower_pkg::*;
#(
    parameter int PC_W  = 64,
    parameter int CNT_W = 32
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               flush,
    upower_decode_stage_if.master   bus,
    output logic [CNT_W-1:0]        dec_count,
    output logic [15:0]             ill_count
);

    bundle_t         dec_bundle;
    bundle_t         main_q, main_d, skid_q, skid_d;
    logic [PC_W-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic            main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic            in_ready_q, in_ready_d;
    logic [CNT_W-1:0] dec_count_q, dec_count_d;
    logic [15:0]     ill_count_q, ill_count_d;
    logic            in_fire, out_fire;

    upower_field_decode u_field_decode (
        .instr  (bus.in_instr),
        .bundle (dec_bundle)
    );

    always_comb begin
        main_d       = main_q;
        main_pc_d    = main_pc_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;
        dec_count_d  = dec_count_q;
        ill_count_d  = ill_count_q;

        in_fire  = bus.in_valid & in_ready_q & ~flush;
        out_fire = main_valid_q & bus.out_ready;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || bus.out_ready) begin
            // in_ready_q is "skid empty", so a full skid never coincides with in_fire
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_pc_d    = skid_pc_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_d       = dec_bundle;
                main_pc_d    = bus.in_pc;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d       = dec_bundle;
            skid_pc_d    = bus.in_pc;
            skid_valid_d = 1'b1;
        end

        in_ready_d = ~skid_valid_d;

        if (out_fire) begin
            dec_count_d = dec_count_q + 1'b1;
            if (main_q.illegal && ill_count_q != 16'hFFFF)
                ill_count_d = ill_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            main_pc_q    <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_pc_q    <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            dec_count_q  <= '0;
            ill_count_q  <= '0;
        end else begin
            main_q       <= main_d;
            main_pc_q    <= main_pc_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            dec_count_q  <= dec_count_d;
            ill_count_q  <= ill_count_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = main_valid_q;
    assign bus.out_fmt     = main_q.fmt;
    assign bus.out_illegal = main_q.illegal;
    assign bus.out_pc      = main_pc_q;
    assign bus.out_opcode  = main_q.opcode;
    assign bus.out_rs      = main_q.rs;
    assign bus.out_rt      = main_q.rt;
    assign bus.out_bo      = main_q.bo;
    assign bus.out_bi      = main_q.bi;
    assign bus.out_si      = main_q.si;
    assign bus.out_ds      = main_q.ds;
    assign bus.out_xox     = main_q.xox;
    assign bus.out_xoxo    = main_q.xoxo;
    assign bus.out_aa      = main_q.aa;
    assign bus.out_xods    = main_q.xods;
    assign dec_count       = dec_count_q;
    assign ill_count       = ill_count_q;

endmodule

`default_nettype wire

// File: tb/tb_upower_decode_stage.sv
// ============================================================================
// tb_upower_decode_stage : directed vectors for the decode stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_upower_decode_stage;
    import upower_pkg::*;

    localparam int PC_W  = 64;
    localparam int CNT_W = 32;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic [CNT_W-1:0] dec_count;
    logic [15:0]      ill_count;
    int               n_checks;
    int               n_pass;

    upower_decode_stage_if #(.PC_W(PC_W)) bus ();

    upower_decode_stage #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .dec_count (dec_count),
        .ill_count (ill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [63:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        #23;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_dec_count", 64'(dec_count),     64'd0);
        check("rst_ill_count", 64'(ill_count),     64'd0);
        check("rst_opcode",    64'(bus.out_opcode), 64'd0);
        rst_n = 1'b1;
        step();

        // add: XO form
        bus.out_ready = 1'b1;
        offer(32'h7CA32214, 64'h1000);
        step();
        bus.in_valid = 1'b0;
        check("add_valid", 64'(bus.out_valid), 64'd1);
        check("add_fmt",   64'(bus.out_fmt),   64'(FMT_XO));
        check("add_xoxo",  64'(bus.out_xoxo),  64'd266);
        check("add_xox",   64'(bus.out_xox),   64'd0);
        check("add_rt",    64'(bus.out_rt),    64'd5);
        check("add_rs",    64'(bus.out_rs),    64'd3);
        check("add_pc",    64'(bus.out_pc),    64'h1000);
        step();
        check("add_dec_count", 64'(dec_count), 64'd1);
        check("add_drained",   64'(bus.out_valid), 64'd0);

        // AND then ld back to back
        offer(32'h7C220038, 64'h1004);
        step();
        check("and_fmt",  64'(bus.out_fmt),  64'(FMT_X));
        check("and_xox",  64'(bus.out_xox),  64'd28);
        check("and_xoxo", 64'(bus.out_xoxo), 64'd0);
        offer(32'hE8610004, 64'h1008);
        step();
        check("ld_valid", 64'(bus.out_valid), 64'd1);
        check("ld_fmt",   64'(bus.out_fmt),   64'(FMT_DS));
        check("ld_ds",    64'(bus.out_ds),    64'd1);
        check("ld_si",    64'(bus.out_si),    64'd0);
        check("ld_xods",  64'(bus.out_xods),  64'd0);
        check("ld_rt",    64'(bus.out_rt),    64'd3);
        check("ld_pc",    64'(bus.out_pc),    64'h1008);

        // illegal opcode 7
        offer(32'h1D201234, 64'h100C);
        step();
        check("ill_fmt",     64'(bus.out_fmt),     64'(FMT_ILL));
        check("ill_flag",    64'(bus.out_illegal), 64'd1);
        check("ill_opcode",  64'(bus.out_opcode),  64'd7);
        check("ill_rt",      64'(bus.out_rt),      64'd0);
        check("ill_si",      64'(bus.out_si),      64'd0);
        // D form addi
        offer(32'h3822FFFF, 64'h1010);
        step();
        check("ill_count1", 64'(ill_count), 64'd1);
        check("d_fmt",  64'(bus.out_fmt),  64'(FMT_D));
        check("d_si",   64'(bus.out_si),   64'hFFFF);
        check("d_ds",   64'(bus.out_ds),   64'd0);
        check("d_xox",  64'(bus.out_xox),  64'd0);
        check("d_flag", 64'(bus.out_illegal), 64'd0);
        // I form: everything but opcode cleared
        offer(32'h4BFFFFFF, 64'h1014);
        step();
        check("i_fmt",    64'(bus.out_fmt),    64'(FMT_I));
        check("i_opcode", 64'(bus.out_opcode), 64'd18);
        check("i_rt",     64'(bus.out_rt),     64'd0);
        check("i_si",     64'(bus.out_si),     64'd0);
        check("i_aa",     64'(bus.out_aa),     64'd0);
        // B form
        offer(32'h4D820012, 64'h1018);
        step();
        check("b_fmt",  64'(bus.out_fmt),  64'(FMT_B));
        check("b_bo",   64'(bus.out_bo),   64'd12);
        check("b_bi",   64'(bus.out_bi),   64'd2);
        check("b_aa",   64'(bus.out_aa),   64'd1);
        check("b_si",   64'(bus.out_si),   64'd0);
        check("b_xoxo", 64'(bus.out_xoxo), 64'd0);
        // opcode 31 with unknown extended opcode
        offer(32'h7C000000, 64'h101C);
        step();
        bus.in_valid = 1'b0;
        check("op31bad_fmt",  64'(bus.out_fmt),     64'(FMT_ILL));
        check("op31bad_flag", 64'(bus.out_illegal), 64'd1);
        step();
        check("dec_count8", 64'(dec_count), 64'd8);
        check("ill_count2", 64'(ill_count), 64'd2);

        // stall: three words offered, two taken
        bus.out_ready = 1'b0;
        offer(32'h38000001, 64'h2000);
        step();
        check("stall_w1_valid", 64'(bus.out_valid), 64'd1);
        check("stall_w1_ready", 64'(bus.in_ready),  64'd1);
        offer(32'h38000002, 64'h2004);
        step();
        check("stall_skid_ready", 64'(bus.in_ready), 64'd0);
        check("stall_hold_si1",   64'(bus.out_si),   64'd1);
        offer(32'h38000003, 64'h2008);
        step();
        check("stall_w3_blocked", 64'(bus.in_ready), 64'd0);
        check("stall_hold_si2",   64'(bus.out_si),   64'd1);
        check("stall_hold_pc",    64'(bus.out_pc),   64'h2000);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("drain_w2_si",    64'(bus.out_si),    64'd2);
        check("drain_w2_valid", 64'(bus.out_valid), 64'd1);
        check("drain_ready",    64'(bus.in_ready),  64'd1);
        step();
        check("drain_empty",  64'(bus.out_valid), 64'd0);
        check("dec_count10",  64'(dec_count),     64'd10);

        // flush with main and skid full plus a word offered
        bus.out_ready = 1'b0;
        offer(32'h38000004, 64'h3000);
        step();
        offer(32'h38000005, 64'h3004);
        step();
        offer(32'h38000006, 64'h3008);
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_valid", 64'(bus.out_valid), 64'd0);
        check("flush_ready", 64'(bus.in_ready),  64'd1);
        check("flush_dec",   64'(dec_count),     64'd10);
        step();
        check("flush_no_w6", 64'(bus.out_valid), 64'd0);
        // word offered with in_ready = 1 during flush is dropped
        offer(32'h38000007, 64'h300C);
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_drop_w7", 64'(bus.out_valid), 64'd0);
        // handshake in the flush cycle still counts
        bus.out_ready = 1'b1;
        offer(32'h38000008, 64'h3010);
        step();
        bus.in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_cnt_valid", 64'(bus.out_valid), 64'd0);
        check("flush_cnt_dec",   64'(dec_count),     64'd11);

        // asynchronous reset mid-stream
        offer(32'h38000009, 64'h4000);
        bus.out_ready = 1'b0;
        step();
        check("pre_arst_valid", 64'(bus.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(bus.out_valid), 64'd0);
        check("arst_dec",   64'(dec_count),     64'd0);
        check("arst_ill",   64'(ill_count),     64'd0);
        check("arst_ready", 64'(bus.in_ready),  64'd1);
        bus.in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/upower_decode_stage.md
# upower_decode_stage

Registered instruction-decode stage for the uPower datapath. Accepts 32-bit instruction words with a valid/ready handshake. Classifies each word into an instruction format and splits it into the field bundle the 64-bit ALU consumes (opcode, rs, rt, bo, bi, si, ds, xox, xoxo, aa, xods). Sits between instruction fetch and the ALU, with a 2-entry skid buffer so back-pressure never drops a word.

## Interface
- `PC_W`, 64, width of the program-counter sideband carried with each instruction
- `CNT_W`, 32, width of the decoded-instruction counter

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous pipeline flush
- `in_valid`  in  1  instruction word valid
- `in_ready`  out  1  stage can accept a word
- `in_instr`  in  32  instruction, MSB = `in_instr[31]`
- `in_pc`  in  PC_W  address of `in_instr`
- `out_valid`  out  1  decoded bundle valid
- `out_ready`  in  1  ALU/issue accepts bundle
- `out_fmt`  out  3  format code (see package)
- `out_illegal`  out  1  unrecognised encoding
- `out_pc`  out  PC_W  pc of bundle
- `out_opcode`  out  6  opcode field
- `out_rs`, `out_rt`, `out_bo`, `out_bi`  out  5 each  register / branch fields
- `out_si`  out  16  immediate
- `out_ds`  out  14  DS displacement
- `out_xox`  out  10  X-form extended opcode
- `out_xoxo`  out  9  XO-form extended opcode
- `out_aa`  out  1  branch AA bit
- `out_xods`  out  2  DS-form sub-opcode
- `dec_count`  out  CNT_W  bundles delivered; wraps
- `ill_count`  out  16  illegal bundles delivered; saturates at 16'hFFFF

## Operation

Field extraction:
- opcode = [31:26]
- rt = bo = [25:21]
- rs = bi = [20:16]
- si = [15:0]
- ds = [15:2]
- xods = [1:0]
- xox = [10:1]
- xoxo = [9:1]
- aa = [1]

Classification, in priority order:
- **X**: opcode 31 and xox ∈ {28, 476, 444, 316, 986}.
- **XO**: opcode 31 and xoxo ∈ {266, 40}.
- **B**: opcode 19.
- **I**: opcode 18.
- **D**: opcode ∈ {14, 15, 24, 26, 28, 32, 34, 36, 37, 38, 40, 42, 44}.
- **DS**: opcode ∈ {58, 62}.
- Anything else is **ILL**.

Field gating (the ALU selects its mode from nonzero fields, so fields foreign to the format are driven 0):
- X: xoxo = 0, si = 0, ds = 0.
- XO: xox = 0, si = 0, ds = 0.
- B: bo, bi, aa valid; si = ds = xox = xoxo = 0.
- I: all fields 0 except opcode.
- D: si valid; ds = xox = xoxo = 0.
- DS: ds and xods valid; si = xox = xoxo = 0.
- ILL: opcode passes through, all other fields 0, `out_illegal` = 1.

Buffering:
- Main output register plus one skid register.
- When the output is stalled, an incoming word goes to skid.
- `in_ready` is registered and equals "skid empty".

Counters:
- `dec_count` increments on each output handshake (`out_valid & out_ready`).
- `ill_count` increments on each such handshake with `out_illegal` = 1.

Flush:
- Clears main and skid valid bits.
- A word offered in the same cycle is discarded even if `in_ready` = 1.
- Counters are not cleared.

## Timing
- Reset values: `out_valid` = 0, `in_ready` = 1, counters = 0, all bundle outputs = 0.
- Latency: a word accepted at edge N is on the outputs with `out_valid` = 1 after edge N when the main register was empty or draining.
- Throughput: 1 word per cycle when `out_ready` is held high.
- Stall:
  - `out_valid` = 1, `out_ready` = 0 → main holds and all outputs are stable.
  - One further word may be accepted into skid.
  - `in_ready` drops the next cycle.
- Drain: when main handshakes and skid is full, skid moves to main at that edge and `in_ready` rises the following cycle.
- No combinational path from `out_ready` to `in_ready`.
- Simultaneous handshakes (in and out in the same cycle, skid empty): main reloads with the new word and there is no bubble.
- Flush has priority over all handshakes. The output handshake in the flush cycle still counts if `out_valid` & `out_ready`.
- Reset mid-operation: state returns to reset values immediately (asynchronous) and in-flight words are lost.

## Structure
- Package `upower_pkg`:
  - format enum: ILL = 0, XO = 1, X = 2, B = 3, I = 4, D = 5, DS = 6
  - opcode constants and extended-opcode constants
  - decoded-bundle struct type
- Sub-module `upower_field_decode`: combinational classifier and gater producing the bundle from a 32-bit word.
- The top level holds the skid/main registers and the counters.

## Test plan
- Stream add (op 31, xoxo 266, rt 5, rs 3), `out_ready` = 1 → bundle one cycle later: fmt XO, xoxo 266, xox 0, rt 5, rs 3; `dec_count` = 1.
- AND (op 31, xox 28) then ld (op 58, ds 1, xods 0) back to back → fmt X with xoxo 0, then fmt DS with ds 1 and si 0, on consecutive cycles.
- Hold `out_ready` = 0 and offer 3 words → first in main, second in skid, third not accepted (`in_ready` = 0). Release → words emerge in order with no loss or duplication.
- Opcode 7 → fmt ILL, `out_illegal` = 1, all fields 0 except opcode 7; `ill_count` = 1.
- `flush` with main and skid full plus a word offered → next cycle `out_valid` = 0, `in_ready` = 1, offered word never appears.
- Deassert `rst_n` mid-stream → `out_valid` = 0 and counters = 0 without waiting for a clock edge.
